// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/writeback and
// stalls on the memory-ready handshake for every memory access.
module mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               memtoreg,
    output logic               regdst,
    output logic               iord,
    output logic [1:0]         pcsrc,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic               irwrite,
    output logic               memwrite,
    output logic               regwrite,
    output logic               pcen,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = STATE_W'(0),
        DECODE  = STATE_W'(1),
        MEMADR  = STATE_W'(2),
        MEMRD   = STATE_W'(3),
        MEMWB   = STATE_W'(4),
        MEMWR   = STATE_W'(5),
        RTYPEEX = STATE_W'(6),
        RTYPEWB = STATE_W'(7),
        BEQEX   = STATE_W'(8),
        ADDIEX  = STATE_W'(9),
        ADDIWB  = STATE_W'(10),
        JEX     = STATE_W'(11)
    } state_t;

    state_t state_q;
    logic   illegal_q;

    logic irw, mw, rw, pcw, br;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH:   if (mem_ready) state_q <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_RTYPE:     state_q <= RTYPEEX;
                        OP_BEQ:       state_q <= BEQEX;
                        OP_ADDI:      state_q <= ADDIEX;
                        OP_J:         state_q <= JEX;
                        default: begin
                            state_q   <= FETCH;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                // op is still the lw/sw that got us here because the IR is not reloaded
                MEMADR:  state_q <= (op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (mem_ready) state_q <= MEMWB;
                MEMWB:   state_q <= FETCH;
                MEMWR:   if (mem_ready) state_q <= FETCH;
                RTYPEEX: state_q <= RTYPEWB;
                RTYPEWB: state_q <= FETCH;
                BEQEX:   state_q <= FETCH;
                ADDIEX:  state_q <= ADDIWB;
                ADDIWB:  state_q <= FETCH;
                JEX:     state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        memtoreg = 1'b0;
        regdst   = 1'b0;
        iord     = 1'b0;
        pcsrc    = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        irw      = 1'b0;
        mw       = 1'b0;
        rw       = 1'b0;
        pcw      = 1'b0;
        br       = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                irw     = mem_ready;
                pcw     = mem_ready;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                rw       = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1;
                mw   = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWB: begin
                regdst = 1'b1;
                rw     = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                br      = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB:  rw = 1'b1;
            JEX: begin
                pcsrc = 2'b10;
                pcw   = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by reset directly so nothing is written while reset is held
    assign irwrite    = irw & reset_n;
    assign memwrite   = mw & reset_n;
    assign regwrite   = rw & reset_n;
    assign pcen       = (pcw | (br & zero)) & reset_n;
    assign illegal_op = illegal_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: directed and random instruction streams checked
// cycle by cycle against a per-instruction state-path model.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       memtoreg, regdst, iord, alusrca, irwrite, memwrite, regwrite, pcen, illegal_op;
    logic [1:0] pcsrc, alusrcb, aluop;
    logic [3:0] dbg_state;
    logic [13:0] act;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: current state code, remaining states of this instruction, sticky flag
    int ms = 0;
    int path[$];
    bit mill = 1'b0;

    mc_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .memtoreg(memtoreg), .regdst(regdst), .iord(iord), .pcsrc(pcsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .irwrite(irwrite),
        .memwrite(memwrite), .regwrite(regwrite), .pcen(pcen),
        .illegal_op(illegal_op), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign act = {memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, aluop,
                  irwrite, memwrite, regwrite, pcen};

    function automatic void load_route(logic [5:0] o);
        case (o)
            6'b100011: path = '{1, 2, 3, 4};
            6'b101011: path = '{1, 2, 5};
            6'b000000: path = '{1, 6, 7};
            6'b001000: path = '{1, 9, 10};
            6'b000100: path = '{1, 8};
            6'b000010: path = '{1, 11};
            default:   path = '{1};
        endcase
    endfunction

    function automatic bit is_legal(logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    endfunction

    function automatic logic [13:0] exp_out(int s, bit mr, bit z);
        logic m2r = 0, rd = 0, io = 0, asa = 0, irw = 0, mw = 0, rw = 0, pce = 0;
        logic [1:0] pcs = 0, asb = 0, aop = 0;
        case (s)
            0:  begin asb = 2'b01; irw = mr; pce = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pce = z; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pce = 1; end
            default: ;
        endcase
        return {m2r, rd, io, pcs, asa, asb, aop, irw, mw, rw, pce};
    endfunction

    // Drive one cycle from a falling edge, compare, advance the model, return at next falling edge
    task automatic model_cycle(input bit mr, output bit mw_o, output bit rw_o);
        logic [13:0] e;
        mem_ready = mr;
        #1;
        e = exp_out(ms, mr, zero);
        n_checks++;
        if (dbg_state !== ms[3:0]) $display("[TB] FAIL state: got %0d expected %0d", dbg_state, ms);
        else n_pass++;
        n_checks++;
        if (act !== e) $display("[TB] FAIL outputs in state %0d: got %b expected %b", ms, act, e);
        else n_pass++;
        n_checks++;
        if (illegal_op !== mill) $display("[TB] FAIL illegal_op: got %b expected %b", illegal_op, mill);
        else n_pass++;
        mw_o = memwrite;
        rw_o = regwrite;
        if ((ms == 0 || ms == 3 || ms == 5) && !mr) begin
        end else if (ms == 0) begin
            load_route(op);
            ms = path.pop_front();
        end else begin
            if (ms == 1 && !is_legal(op)) mill = 1'b1;
            ms = (path.size() > 0) ? path.pop_front() : 0;
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [5:0] o, input bit z, input int stalls, input bit rnd,
                             output int cycles, output int memw, output int regw);
        int stall_left;
        int last;
        bit left, mw, rw, mr;
        op = o;
        zero = z;
        cycles = 0;
        memw = 0;
        regw = 0;
        stall_left = stalls;
        last = ms;
        left = (ms != 0);
        for (int i = 0; i < 80; i++) begin
            if (ms != last) begin
                stall_left = stalls;
                last = ms;
            end
            if (rnd) mr = (ms inside {0, 3, 5}) ? ($urandom_range(0, 2) != 0) : 1'($urandom);
            else if ((ms == 3 || ms == 5) && stall_left > 0) begin
                mr = 1'b0;
                stall_left--;
            end else mr = 1'b1;
            model_cycle(mr, mw, rw);
            cycles++;
            memw += int'(mw);
            regw += int'(rw);
            if (ms == 0 && left) return;
            left = (ms != 0);
        end
        n_checks++;
        $display("[TB] FAIL timeout: op %b did not return to FETCH within 80 cycles", o);
    endtask

    task automatic test_reset();
        bit mw, rw;
        int c, m, r;
        reset_n = 1'b1;
        mem_ready = 1'b1;
        op = 6'b000000;
        zero = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (dbg_state !== 4'd0 || {irwrite, memwrite, regwrite, pcen} !== 4'b0 || illegal_op !== 1'b0)
            $display("[TB] FAIL power-on reset: state %0d enables %b illegal %b, expected 0 0000 0",
                     dbg_state, {irwrite, memwrite, regwrite, pcen}, illegal_op);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        model_cycle(1'b1, mw, rw);
        model_cycle(1'b1, mw, rw);
        mem_ready = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if (dbg_state !== 4'd0 || {irwrite, memwrite, regwrite, pcen} !== 4'b0 || alusrcb !== 2'b01)
            $display("[TB] FAIL mid-RTYPEEX reset: state %0d enables %b alusrcb %b, expected 0 0000 01",
                     dbg_state, {irwrite, memwrite, regwrite, pcen}, alusrcb);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (dbg_state !== 4'd0 || {irwrite, memwrite, regwrite, pcen} !== 4'b0)
            $display("[TB] FAIL reset held over edge: state %0d enables %b, expected 0 0000",
                     dbg_state, {irwrite, memwrite, regwrite, pcen});
        else n_pass++;
        ms = 0;
        path.delete();
        mill = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(6'b000000, 1'b0, 0, 1'b0, c, m, r);
    endtask

    task automatic test_latency();
        logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
        int lat[6] = '{5, 4, 4, 4, 3, 3};
        int c, m, r;
        for (int i = 0; i < 6; i++) begin
            run_instr(ops[i], 1'b1, 0, 1'b0, c, m, r);
            n_checks++;
            if (c !== lat[i]) $display("[TB] FAIL latency op %b: got %0d cycles expected %0d", ops[i], c, lat[i]);
            else n_pass++;
        end
    endtask

    task automatic test_sw_stall();
        int c, m, r;
        run_instr(6'b101011, 1'b0, 3, 1'b0, c, m, r);
        n_checks++;
        if (m !== 4 || r !== 0 || c !== 7)
            $display("[TB] FAIL sw stall: memwrite %0d regwrite %0d cycles %0d, expected 4 0 7", m, r, c);
        else n_pass++;
        run_instr(6'b100011, 1'b0, 2, 1'b0, c, m, r);
        n_checks++;
        if (r !== 1 || c !== 7)
            $display("[TB] FAIL lw stall: regwrite %0d cycles %0d, expected 1 7", r, c);
        else n_pass++;
    endtask

    task automatic test_beq();
        int c, m, r;
        run_instr(6'b000100, 1'b1, 0, 1'b0, c, m, r);
        run_instr(6'b000100, 1'b0, 0, 1'b0, c, m, r);
    endtask

    task automatic test_illegal();
        int c, m, r;
        run_instr(6'b111111, 1'b0, 0, 1'b0, c, m, r);
        n_checks++;
        if (c !== 2) $display("[TB] FAIL illegal op path: got %0d cycles expected 2", c);
        else n_pass++;
        run_instr(6'b100011, 1'b0, 0, 1'b1, c, m, r);
        run_instr(6'b001000, 1'b1, 0, 1'b1, c, m, r);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (illegal_op !== 1'b0) $display("[TB] FAIL illegal clear on reset: got %b expected 0", illegal_op);
        else n_pass++;
        ms = 0;
        path.delete();
        mill = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(6'b000010, 1'b0, 0, 1'b0, c, m, r);
    endtask

    task automatic test_random();
        logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
        logic [5:0] o;
        int c, m, r;
        for (int i = 0; i < 60; i++) begin
            o = ($urandom_range(0, 14) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            run_instr(o, 1'($urandom), 0, 1'b1, c, m, r);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sw_stall();
        test_beq();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
